// File: rtl/first_counter_sequencer.sv
// first_counter_sequencer
// Runs the 4-bit first_counter for a programmed number of full wraps.
// Each run clears the counter, enables it until the requested number of
// overflow pulses has been seen, then reports completion with a done pulse.
// While running, a shadow model of the counter checks every value and every
// overflow pulse, and raises a sticky err flag on any disagreement.
module first_counter_sequencer #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active-low
    input  logic              start,
    input  logic              abort,
    input  logic [WRAP_W-1:0] num_wraps,
    input  logic [3:0]        counter_out,
    input  logic              overflow_out,
    output logic              cnt_enable,
    output logic              cnt_clear,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WRAP_W-1:0] wraps_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [WRAP_W-1:0] target_q,  target_d;
    logic [WRAP_W-1:0] wraps_q,   wraps_d;
    logic [3:0]        exp_q,     exp_d;      // counter value the model expects this cycle
    logic              ovf_exp_q, ovf_exp_d;  // overflow pulse the model expects this cycle
    logic              err_q,     err_d;
    logic              aborted_q, aborted_d;

    // Next-state, run bookkeeping and counter model.
    // NOTE: every _d signal takes its _q value first, so no path through the
    // case statement leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        wraps_d   = wraps_q;
        exp_d     = exp_q;
        ovf_exp_d = ovf_exp_q;
        err_d     = err_q;
        aborted_d = aborted_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A new run wipes the previous run's status.
                    target_d  = num_wraps;
                    wraps_d   = '0;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    // A zero-length request completes without touching the counter.
                    state_d   = (num_wraps == '0) ? S_DONE : S_CLEAR;
                end
            end

            S_CLEAR: begin
                // The counter reads 0 in the first RUN cycle; no overflow is pending.
                exp_d     = 4'd0;
                ovf_exp_d = 1'b0;
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                // Model: value steps mod 16; overflow follows a 15->0 step by one cycle.
                exp_d     = exp_q + 4'd1;
                ovf_exp_d = (exp_q == 4'hF);
                // A mismatch is recorded but never ends the run.
                if ((counter_out != exp_q) || (overflow_out != ovf_exp_q)) begin
                    err_d = 1'b1;
                end
                if (overflow_out) begin
                    wraps_d = wraps_q + WRAP_W'(1);
                end
                // Reaching the target takes priority over a coincident abort.
                if (overflow_out && (wraps_d == target_q)) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            wraps_q   <= '0;
            exp_q     <= 4'd0;
            ovf_exp_q <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            wraps_q   <= wraps_d;
            exp_q     <= exp_d;
            ovf_exp_q <= ovf_exp_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    // Control outputs decode the state register alone, so no input reaches them combinationally.
    assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign cnt_clear  = (state_q == S_CLEAR);
    assign cnt_enable = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

    assign aborted    = aborted_q;
    assign wraps_done = wraps_q;
    assign err        = err_q;

endmodule

// File: tb/tb_first_counter_sequencer.sv
// tb_first_counter_sequencer
// Drives the sequencer against a behavioural 4-bit counter that can be told
// to misbehave (skip 7->9, or emit a spurious overflow). Each run is
// predicted as a whole from the request, abort cycle and fault: the list of
// overflow cycles gives the completion cycle, and the control outputs are
// checked cycle by cycle against that schedule.
module tb_first_counter_sequencer;

    localparam int WRAP_W = 8;
    localparam int F_NONE = 0, F_SKIP = 1, F_EXTRA = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [WRAP_W-1:0] num_wraps;
    logic [3:0]        counter_out;
    logic              overflow_out;
    logic              cnt_enable;
    logic              cnt_clear;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [WRAP_W-1:0] wraps_done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    first_counter_sequencer #(.WRAP_W(WRAP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_wraps    (num_wraps),
        .counter_out  (counter_out),
        .overflow_out (overflow_out),
        .cnt_enable   (cnt_enable),
        .cnt_clear    (cnt_clear),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .wraps_done   (wraps_done),
        .err          (err)
    );

    // Behavioural counter with optional faults
    logic [3:0] cnt_q;
    logic       ovf_q;
    logic       skip_en = 1'b0;
    logic       skipped;
    logic       inject  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
            skipped <= 1'b0;
        end else if (cnt_clear) begin
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
            skipped <= 1'b0;
        end else if (cnt_enable) begin
            ovf_q <= (cnt_q == 4'hF);
            if (skip_en && !skipped && cnt_q == 4'd7) begin
                cnt_q   <= 4'd9;
                skipped <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end else begin
            ovf_q <= 1'b0;
        end
    end

    assign counter_out  = cnt_q;
    assign overflow_out = ovf_q | inject;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Cycle c counts clock periods after the edge that accepted start (cycle 1 follows it).
    // a = cycle in which abort is held high (0 = never); x = cycle of a spurious overflow.
    task automatic run_case(input int n, input int a, input int fault, input int x);
        int ovf_cyc[$];
        int d, c_n, exp_w, exp_cnt, first_bad;
        logic exp_ab, exp_err;

        // Prediction: when the overflow pulses arrive, and which event ends the run.
        if (n == 0) begin
            d = 1; exp_w = 0; exp_ab = 1'b0;
        end else begin
            // A healthy counter wraps every 16 cycles, first pulse in cycle 18;
            // skipping a value in the first wrap pulls every pulse one cycle earlier.
            for (int k = 1; k <= n; k++) ovf_cyc.push_back(16 * k + ((fault == F_SKIP) ? 1 : 2));
            if (fault == F_EXTRA) ovf_cyc.push_back(x);
            ovf_cyc.sort();
            c_n = ovf_cyc[n - 1];
            if (a == 1) begin
                d = 2; exp_w = 0; exp_ab = 1'b1;
            end else if (a >= 2 && a < c_n) begin
                d = a + 1; exp_ab = 1'b1; exp_w = 0;
                foreach (ovf_cyc[i]) if (ovf_cyc[i] <= a) exp_w++;
            end else begin
                d = c_n + 1; exp_w = n; exp_ab = 1'b0;
            end
        end
        first_bad = (fault == F_SKIP) ? 10 : x;
        exp_err   = (fault != F_NONE) && (n != 0) && (first_bad >= 2) && (first_bad < d);
        exp_cnt   = (d >= 2) ? ((d - 2 + ((fault == F_SKIP && d - 2 >= 8) ? 1 : 0)) % 16) : 0;

        skip_en = (fault == F_SKIP);
        @(negedge clk);
        num_wraps = WRAP_W'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        num_wraps = WRAP_W'($urandom);   // must be ignored once latched

        for (int c = 1; c <= d + 1; c++) begin
            abort  = (c == a);
            inject = (fault == F_EXTRA) && (c == x);
            start  = (c <= d) ? 1'($urandom_range(0, 1)) : 1'b0;  // ignored outside IDLE
            @(negedge clk);
            check("ctl{busy,en,clr,done}", {28'd0, busy, cnt_enable, cnt_clear, done},
                  {28'd0, (c < d), (c >= 2 && c < d), (c == 1 && d > 1), (c == d)});
            if (c == 1) begin
                check("start_clears_err", err, 0);
                check("start_clears_aborted", aborted, 0);
                check("start_clears_wraps", wraps_done, 0);
            end
            if (c == d) begin
                check("wraps_done", wraps_done, exp_w);
                check("aborted", aborted, exp_ab);
                check("err", err, exp_err);
                if (d >= 2) check("counter_rest", counter_out, exp_cnt);
            end
            @(posedge clk); #1;
        end
        abort   = 1'b0;
        inject  = 1'b0;
        start   = 1'b0;
        skip_en = 1'b0;
    endtask

    initial begin
        int n, a, f, x;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        num_wraps = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, cnt_enable, cnt_clear, done, aborted, err, wraps_done},
              0);
        @(negedge clk);
        reset = 1'b1;

        run_case(1, 0, F_NONE, 0);       // single wrap, rests at 1
        run_case(3, 0, F_NONE, 0);       // done in cycle 51
        run_case(0, 0, F_NONE, 0);       // zero-length run
        run_case(5, 40, F_NONE, 0);      // abort after 2nd overflow
        run_case(2, 34, F_NONE, 0);      // abort coincident with final overflow
        run_case(2, 0, F_SKIP, 0);       // counter skips 7->9
        run_case(1, 0, F_NONE, 0);       // err cleared by next start
        run_case(2, 0, F_EXTRA, 9);      // spurious overflow pulse
        run_case(3, 1, F_NONE, 0);       // abort during CLEAR

        // Reset in the middle of a run once two wraps have been counted
        @(negedge clk);
        num_wraps = WRAP_W'(5);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("mid_run_wraps", wraps_done, 2);
        check("mid_run_enable", cnt_enable, 1);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {busy, cnt_enable, cnt_clear, done, aborted, err, wraps_done},
              0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_case(1, 0, F_NONE, 0);

        run_case(255, 0, F_NONE, 0);     // largest request

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 4);
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 16 * n + 4) : 0;
            f = (n == 0) ? F_NONE : $urandom_range(0, 2);
            x = 0;
            if (f == F_EXTRA) begin
                x = $urandom_range(3, 16 * n + 1);
                if ((x - 2) % 16 == 0) x++;
            end
            run_case(n, a, f, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/first_counter_sequencer.md
# first_counter_sequencer

Controller that sequences the 4-bit `first_counter` wrap counter. It clears the counter, enables it for a programmed number of full wraps counted via `overflow_out`, then stops and reports completion. It checks every counter value and overflow pulse against an internal model and flags any mismatch. It sits between a host start/done handshake and the counter's `enable` input plus its synchronous clear.

## Interface
- `WRAP_W`, 8, width of wrap-count request and progress
- `clk` input 1, single clock, rising edge
- `reset` input 1, asynchronous, active-low; all state cleared while low
- `start` input 1, sampled in IDLE only; request a run
- `abort` input 1, sampled in CLEAR/RUN; stop run early
- `num_wraps` input WRAP_W, wraps requested; latched when `start` is accepted
- `counter_out` input 4, counter value
- `overflow_out` input 1, counter wrap pulse
- `cnt_enable` output 1, drives counter `enable`
- `cnt_clear` output 1, synchronous clear to counter, one cycle
- `busy` output 1, high in CLEAR and RUN
- `done` output 1, one-cycle pulse at end of every run (normal, abort, or zero-length)
- `aborted` output 1, valid with `done`, held until next accepted `start`
- `wraps_done` output WRAP_W, overflow pulses counted in the current/last run
- `err` output 1, sticky model mismatch; cleared on accepted `start`

## Operation
- Counter contract: `cnt_clear` at an edge sets `counter_out`=0. `cnt_enable` high at an edge increments mod 16. `overflow_out` is registered and high for exactly the one cycle after a 15->0 increment.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: `start`=1, `num_wraps`!=0 -> CLEAR. Latch target; clear `wraps_done`, `err`, `aborted`.
- IDLE: `start`=1, `num_wraps`=0 -> DONE directly. `wraps_done`=0, no counter activity.
- CLEAR: `cnt_clear`=1, `cnt_enable`=0. Next state RUN unconditionally, unless `abort` -> DONE with `aborted`=1.
- RUN: `cnt_enable`=1. Model value `exp` starts at 0 in the first RUN cycle and increments mod 16 each RUN cycle.
- RUN, each cycle: `counter_out`!=`exp` -> set `err`.
- RUN, each cycle: `overflow_out`=1 when not expected, or missing in the cycle after `exp` wraps 15->0 -> set `err`.
- RUN, `overflow_out`=1 at an edge: `wraps_done`+=1. If new value equals target -> DONE.
- RUN, `abort`=1 without the final overflow: -> DONE, `aborted`=1, `wraps_done` holds its partial count.
- DONE: `done`=1 for one cycle, `cnt_enable`=0. Next state IDLE.
- `start` outside IDLE is ignored. `num_wraps` changes after acceptance are ignored.
- `err` only updates in RUN. It is not an exit condition; the run continues.

## Timing
- Reset (async assert): IDLE. `cnt_enable`, `cnt_clear`, `busy`, `done`, `aborted`, `err`=0; `wraps_done`=0.
- Reset release: takes effect on the next rising edge.
- Reset mid-run: `cnt_enable` drops immediately. The counter is reset by its own reset.
- `start` sampled at edge E0 -> CLEAR during cycle 1 -> RUN from cycle 2.
- Run of N wraps: RUN lasts 16N+1 cycles. The Nth `overflow_out` is sampled at the edge ending RUN cycle 16N+1. That edge also increments the counter, so `counter_out` rests at 1.
- `done` is high in the cycle after the last RUN cycle. `busy` is low in the same cycle. IDLE follows; a new `start` can be accepted in that IDLE cycle.
- Zero-wrap start: `done` in cycle 1. `busy` is never high.
- Simultaneous `abort` and final overflow: the completion wins. `wraps_done`=target, `aborted`=0.
- Max request: `num_wraps`=2^WRAP_W-1. `wraps_done` never wraps, because it stops at the target.
- Outputs are registered except `busy`/`cnt_enable`/`cnt_clear`/`done`, which are decoded from state only (no input-to-output combinational path).

## Test plan
- Reset low mid-RUN at `wraps_done`=2 -> all outputs 0 immediately. After release, `start` with `num_wraps`=1 runs normally.
- `num_wraps`=1, `start` pulse -> `cnt_clear` one cycle, then `cnt_enable` for 17 cycles, then `done` pulse. Final state: `wraps_done`=1, `counter_out`=1, `err`=0, `aborted`=0.
- `num_wraps`=3 -> `overflow_out` seen 3 times, 16 cycles apart. `done` at cycle 51 after the start edge; `wraps_done`=3.
- `num_wraps`=0 -> `done` in the next cycle. `cnt_enable`/`cnt_clear` stay 0; `wraps_done`=0.
- `num_wraps`=5, `abort` after the 2nd overflow -> `done`, `aborted`=1, `wraps_done`=2, `cnt_enable` low. Repeat with `abort` coincident with the final overflow of `num_wraps`=2 -> `aborted`=0, `wraps_done`=2.
- Counter model fault (counter skips 7->9, or extra overflow pulse) during `num_wraps`=2 -> `err` goes high and stays high, run still completes with `wraps_done`=2. Next `start` clears `err`.
